// File: rtl/playfield_mem_arbiter_pkg.sv
// Shared types and default sizing for the playfield memory arbiter and its
// transfer sequencer.
package playfield_mem_arbiter_pkg;

  localparam int CELLS_PER_ROW    = 10;
  localparam int DEF_ROWS         = 20;
  localparam int DEF_STARVE_LIMIT = 4;

  typedef logic [5:0] address_t;
  typedef logic [2:0] cell_t;
  typedef logic [3:0] idx_t;

  typedef enum logic [2:0] {
    XS_IDLE,
    XS_START,
    XS_XFER,
    XS_DONE,
    XS_REJECT
  } xfer_state_t;

  typedef enum logic {
    OWN_DISP = 1'b0,
    OWN_GAME = 1'b1
  } owner_t;

  // Everything about a transaction that is frozen at the grant edge.
  typedef struct packed {
    owner_t   owner;
    logic     we;
    logic     row_ok;
    address_t row;
  } grant_t;

  function automatic logic row_in_range(input address_t row, input int rows);
    return int'(row) < rows;
  endfunction

endpackage

// File: rtl/mem_xfer_seq.sv
// Sequences one memory transaction (start beat, CELLS cont beats, done) and
// captures read data; out-of-range rows take a short reject path instead.
module mem_xfer_seq
  import playfield_mem_arbiter_pkg::*;
#(
  parameter int CELLS = CELLS_PER_ROW
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     go_i,
  input  grant_t   grant_i,
  input  cell_t    wdata_i,
  input  cell_t    mem_rdata_i,
  output logic     idle_o,
  output idx_t     xfer_idx_o,
  output logic     rd_valid_o,
  output idx_t     rd_idx_o,
  output cell_t    rd_data_o,
  output logic     rd_owner_o,
  output logic     done_o,
  output owner_t   done_owner_o,
  output logic     done_err_o,
  output logic     mem_start_o,
  output logic     mem_we_o,
  output logic     mem_cont_o,
  output address_t mem_addr_o,
  output cell_t    mem_wdata_o
);

  localparam idx_t LAST_BEAT = idx_t'(CELLS - 1);

  xfer_state_t state_q, state_d;
  idx_t        beat_q, beat_d;
  grant_t      txn_q;
  logic        capture;
  logic        rd_valid_q, rd_owner_q;
  idx_t        rd_idx_q;
  cell_t       rd_data_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= XS_IDLE;
      beat_q  <= '0;
      txn_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (go_i && state_q == XS_IDLE) txn_q <= grant_i;
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    unique case (state_q)
      XS_IDLE: begin
        if (go_i) begin
          state_d = grant_i.row_ok ? XS_START : XS_REJECT;
          beat_d  = '0;
        end
      end
      XS_START:  state_d = XS_XFER;
      XS_XFER: begin
        if (beat_q == LAST_BEAT) state_d = XS_DONE;
        else                     beat_d  = beat_q + idx_t'(1);
      end
      XS_REJECT: state_d = XS_DONE;
      XS_DONE:   state_d = XS_IDLE;
      default:   state_d = XS_IDLE;
    endcase
  end

  always_comb begin
    idle_o       = (state_q == XS_IDLE);
    mem_start_o  = (state_q == XS_START);
    mem_cont_o   = (state_q == XS_XFER);
    mem_we_o     = mem_start_o & txn_q.we;
    mem_addr_o   = mem_start_o ? txn_q.row : '0;
    xfer_idx_o   = mem_cont_o ? beat_q : '0;
    mem_wdata_o  = (mem_cont_o && txn_q.we) ? wdata_i : '0;
    done_o       = (state_q == XS_DONE);
    done_owner_o = txn_q.owner;
    done_err_o   = done_o & ~txn_q.row_ok;
    capture      = mem_cont_o & ~txn_q.we;
  end

  // The memory presents the cell for beat i until the edge that ends beat i.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_idx_q   <= '0;
      rd_data_q  <= '0;
      rd_owner_q <= 1'b0;
    end else begin
      rd_valid_q <= capture;
      rd_idx_q   <= capture ? beat_q : '0;
      rd_data_q  <= capture ? mem_rdata_i : '0;
      rd_owner_q <= capture ? txn_q.owner : 1'b0;
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_idx_o   = rd_idx_q;
  assign rd_data_o  = rd_data_q;
  assign rd_owner_o = rd_owner_q;

endmodule

// File: rtl/playfield_mem_arbiter.sv
// Shares the serial playfield memory between the display fetcher and the game
// logic: arbitration with starvation relief, row range check, sequencer.
module playfield_mem_arbiter
  import playfield_mem_arbiter_pkg::*;
#(
  parameter int CELLS        = CELLS_PER_ROW,
  parameter int ROWS         = DEF_ROWS,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       disp_req,
  input  logic [5:0] disp_row,
  input  logic       game_req,
  input  logic       game_we,
  input  logic [5:0] game_row,
  input  logic [2:0] game_wdata,
  output logic [3:0] xfer_idx,
  output logic       rd_valid,
  output logic [3:0] rd_idx,
  output logic [2:0] rd_data,
  output logic       rd_owner,
  output logic       disp_done,
  output logic       game_done,
  output logic       game_err,
  output logic       mem_start,
  output logic       mem_write_enable,
  output logic       mem_cont,
  output logic [5:0] mem_addr,
  output logic [2:0] mem_data_out,
  input  logic [2:0] mem_data_in
);

  localparam int            SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_q, starve_d;
  logic          seq_idle, pick_disp, pick_game;
  grant_t        grant;
  logic          seq_done, seq_done_err;
  owner_t        seq_done_owner;

  // Display has priority until it has won STARVE_LIMIT times in a row while
  // the game was waiting; the count only resets when the game is served.
  always_comb begin
    pick_disp = seq_idle && disp_req && ((starve_q < STARVE_MAX) || !game_req);
    pick_game = seq_idle && game_req && !pick_disp;
    grant     = '0;
    starve_d  = starve_q;
    if (pick_disp) begin
      grant.owner  = OWN_DISP;
      grant.row    = disp_row;
      grant.row_ok = row_in_range(disp_row, ROWS);
      if (game_req && (starve_q < STARVE_MAX)) starve_d = starve_q + SW'(1);
    end else if (pick_game) begin
      grant.owner  = OWN_GAME;
      grant.we     = game_we;
      grant.row    = game_row;
      grant.row_ok = row_in_range(game_row, ROWS);
      starve_d     = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end

  mem_xfer_seq #(.CELLS(CELLS)) u_seq (
    .clk          (clk),
    .reset        (reset),
    .go_i         (pick_disp | pick_game),
    .grant_i      (grant),
    .wdata_i      (game_wdata),
    .mem_rdata_i  (mem_data_in),
    .idle_o       (seq_idle),
    .xfer_idx_o   (xfer_idx),
    .rd_valid_o   (rd_valid),
    .rd_idx_o     (rd_idx),
    .rd_data_o    (rd_data),
    .rd_owner_o   (rd_owner),
    .done_o       (seq_done),
    .done_owner_o (seq_done_owner),
    .done_err_o   (seq_done_err),
    .mem_start_o  (mem_start),
    .mem_we_o     (mem_write_enable),
    .mem_cont_o   (mem_cont),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_data_out)
  );

  assign disp_done = seq_done && (seq_done_owner == OWN_DISP);
  assign game_done = seq_done && (seq_done_owner == OWN_GAME);
  assign game_err  = seq_done_err && (seq_done_owner == OWN_GAME);

endmodule
